// File: rtl/tl_phase_sched_pkg.sv
// Shared phase encodings and lamp codes for the traffic-light phase scheduler.
package tl_phase_sched_pkg;

  typedef enum logic [2:0] {
    PH_A_G  = 3'b000,
    PH_A_Y  = 3'b001,
    PH_AL_G = 3'b010,
    PH_AL_Y = 3'b011,
    PH_B_G  = 3'b100,
    PH_B_Y  = 3'b101,
    PH_BL_G = 3'b110,
    PH_BL_Y = 3'b111
  } phase_t;

  localparam logic [1:0] LAMP_G = 2'b00;
  localparam logic [1:0] LAMP_Y = 2'b01;
  localparam logic [1:0] LAMP_R = 2'b10;

  // Bit 0 of the encoding separates the yellow half of each lamp group.
  function automatic logic is_yellow(input phase_t p);
    return p[0];
  endfunction

endpackage

// File: rtl/tl_phase_ns.sv
// Combinational exit decision and successor phase for the traffic-light scheduler.
// Optional TL_SKIP_LEFT_EN: skip an idle left-turn phase at the end of a yellow.
module tl_phase_ns
  import tl_phase_sched_pkg::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MAX_GREEN  = 8,
  parameter int YEL_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  phase_t           phase,
  input  logic [CNT_W-1:0] phase_cnt,
  input  logic             Ta,
  input  logic             Tal,
  input  logic             Tb,
  input  logic             Tbl,
  output logic             exit_now,
  output phase_t           phase_nxt
);

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YEL_CYCLES - 1);

  logic [3:0] sens;
  logic       own_req;
  logic       other_req;

  assign sens = {Tbl, Tb, Tal, Ta};

  // Lamp group index phase[2:1] lines up with the sensor vector ordering.
  always_comb begin
    own_req   = sens[phase[2:1]];
    other_req = |(sens & ~(4'b0001 << phase[2:1]));
    if (is_yellow(phase)) begin
      exit_now = (phase_cnt == YEL_M1);
    end else begin
      exit_now = ((phase_cnt >= MIN_M1) && !own_req) ||
                 ((phase_cnt == MAX_M1) && other_req);
    end
  end

  always_comb begin
    phase_nxt = phase_t'(3'(phase + 3'd1));
`ifdef TL_SKIP_LEFT_EN
    if (phase == PH_A_Y && !Tal) phase_nxt = PH_B_G;
    if (phase == PH_B_Y && !Tbl) phase_nxt = PH_A_G;
`endif
  end

endmodule

// File: rtl/tl_phase_sched.sv
// Timed 8-phase traffic-light scheduler: phase/timer registers and Moore lamp decode.
// Optional TL_SKIP_LEFT_EN (handled in tl_phase_ns) skips idle left-turn phases.
//   state   | meaning
//   PH_A_G  | A through green
//   PH_A_Y  | A through yellow
//   PH_AL_G | A left arrow green
//   PH_AL_Y | A left arrow yellow
//   PH_B_G  | B through green
//   PH_B_Y  | B through yellow
//   PH_BL_G | B left arrow green
//   PH_BL_Y | B left arrow yellow
module tl_phase_sched
  import tl_phase_sched_pkg::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MAX_GREEN  = 8,
  parameter int YEL_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             Ta,
  input  logic             Tal,
  input  logic             Tb,
  input  logic             Tbl,
  output logic [1:0]       La,
  output logic [1:0]       Lal,
  output logic [1:0]       Lb,
  output logic [1:0]       Lbl,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);

  phase_t           phase_q, phase_d, phase_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exit_now;
  logic [1:0]       lamp_on;

  tl_phase_ns #(
    .MIN_GREEN  (MIN_GREEN),
    .MAX_GREEN  (MAX_GREEN),
    .YEL_CYCLES (YEL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ns (
    .phase     (phase_q),
    .phase_cnt (cnt_q),
    .Ta        (Ta),
    .Tal       (Tal),
    .Tb        (Tb),
    .Tbl       (Tbl),
    .exit_now  (exit_now),
    .phase_nxt (phase_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_A_G;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // A held green parks at MAX_GREEN-1 so the forced exit stays armed.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (exit_now) begin
        phase_d = phase_nxt;
        cnt_d   = '0;
      end else if (is_yellow(phase_q) || cnt_q != MAX_M1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    La      = LAMP_R;
    Lal     = LAMP_R;
    Lb      = LAMP_R;
    Lbl     = LAMP_R;
    lamp_on = is_yellow(phase_q) ? LAMP_Y : LAMP_G;
    case (phase_q[2:1])
      2'd0:    La  = lamp_on;
      2'd1:    Lal = lamp_on;
      2'd2:    Lb  = lamp_on;
      default: Lbl = lamp_on;
    endcase
  end

  assign phase     = phase_q;
  assign phase_cnt = cnt_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Self-checking bench for tl_phase_sched: vector table feeding a scoreboard queue.
module tb_tl_phase_sched;

  localparam int MIN_G = 3;
  localparam int MAX_G = 8;
  localparam int YEL   = 2;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          Ta = 1'b0, Tal = 1'b0, Tb = 1'b0, Tbl = 1'b0;
  logic [1:0]    La, Lal, Lb, Lbl;
  logic [2:0]    phase;
  logic [CW-1:0] phase_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          tk;
    logic [3:0]    sens;   // {Tbl, Tb, Tal, Ta}
    logic [2:0]    ph;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  tl_phase_sched #(
    .MIN_GREEN  (MIN_G),
    .MAX_GREEN  (MAX_G),
    .YEL_CYCLES (YEL),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .Ta        (Ta),
    .Tal       (Tal),
    .Tb        (Tb),
    .Tbl       (Tbl),
    .La        (La),
    .Lal       (Lal),
    .Lb        (Lb),
    .Lbl       (Lbl),
    .phase     (phase),
    .phase_cnt (phase_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_lamps(input logic [2:0] p);
    logic [7:0] l;
    l = 8'b10_10_10_10;
    l[7 - 2*p[2:1] -: 2] = p[0] ? 2'b01 : 2'b00;
    return l;
  endfunction

  function automatic logic [2:0] exp_next(input logic [2:0] p, input logic [3:0] s);
    logic [2:0] n;
    n = p + 3'd1;
`ifdef TL_SKIP_LEFT_EN
    if (p == 3'b001 && !s[1]) n = 3'b100;
    if (p == 3'b101 && !s[3]) n = 3'b000;
`else
    if (s == 4'hF) n = p + 3'd1;
`endif
    return n;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] p, input logic [CW-1:0] c);
    chk({tag, " phase"}, int'(phase), int'(p));
    chk({tag, " phase_cnt"}, int'(phase_cnt), int'(c));
    chk({tag, " lamps"}, int'({La, Lal, Lb, Lbl}), int'(exp_lamps(p)));
  endtask

  always @(posedge clk) begin
    vec_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_state("sb", e.ph, e.cnt);
    end
  end

  task automatic add(input logic tk, input logic [3:0] s, input logic [2:0] p, input int c);
    vec_t v;
    v.tk = tk; v.sens = s; v.ph = p; v.cnt = CW'(c);
    vecs.push_back(v);
  endtask

  // Idle-style run: own sensors low, so greens last MIN_G ticks and yellows YEL.
  task automatic gen_run(input int period, input int nticks, input logic [3:0] s);
    logic [2:0] p;
    int c, dwell;
    p = 3'b000; c = 0;
    for (int t = 0; t < nticks; t++) begin
      for (int j = 1; j < period; j++) add(1'b0, s, p, c);
      dwell = p[0] ? YEL : MIN_G;
      if (c + 1 == dwell) begin
        p = exp_next(p, s);
        c = 0;
      end else begin
        c++;
      end
      add(1'b1, s, p, c);
    end
  endtask

  task automatic apply_vecs();
    foreach (vecs[i]) begin
      @(negedge clk);
      tick = vecs[i].tk;
      {Tbl, Tb, Tal, Ta} = vecs[i].sens;
      sb.push_back(vecs[i]);
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    chk("sb drained", sb.size(), 0);
    @(negedge clk);
    reset_n = 1'b0; tick = 1'b0; {Tbl, Tb, Tal, Ta} = 4'h0;
    #1 chk_state("in reset", 3'b000, '0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_to_101;
    do_reset();

    // Reset state holds with tick low, sensors ignored.
    for (int i = 0; i < 5; i++) add(1'b0, 4'hF, 3'b000, 0);
    apply_vecs();

    // Idle run: 20 ticks returns to A green (two skip-left periods when enabled).
    gen_run(1, 20, 4'h0);
    apply_vecs();

    // Ta held with Tb pending: forced out after MAX_G ticks.
    do_reset();
    for (int k = 1; k < MAX_G; k++) add(1'b1, 4'b0101, 3'b000, k);
    add(1'b1, 4'b0101, 3'b001, 0);
    apply_vecs();

    // Ta held alone: counter saturates, then exits once Ta drops.
    do_reset();
    for (int k = 1; k < MAX_G; k++) add(1'b1, 4'b0001, 3'b000, k);
    for (int k = 0; k < 5; k++) add(1'b1, 4'b0001, 3'b000, MAX_G - 1);
    add(1'b0, 4'b0000, 3'b000, MAX_G - 1);
    add(1'b1, 4'b0000, 3'b001, 0);
    apply_vecs();

    // Tick every 4th cycle: same sequence, holds between ticks.
    do_reset();
    gen_run(4, 20, 4'h0);
    apply_vecs();

    // Tal requested: A-left is entered, then held by its own sensor until released.
    do_reset();
    gen_run(1, 5, 4'b0010);
    for (int k = 1; k < MAX_G; k++) add(1'b1, 4'b0010, 3'b010, k);
    add(1'b1, 4'b0010, 3'b010, MAX_G - 1);
    add(1'b1, 4'b0010, 3'b010, MAX_G - 1);
    add(1'b1, 4'b0000, 3'b011, 0);
    apply_vecs();

    // Reach B yellow, then reset between clock edges.
    do_reset();
`ifdef TL_SKIP_LEFT_EN
    n_to_101 = 9;
`else
    n_to_101 = 14;
`endif
    gen_run(1, n_to_101, 4'h0);
    apply_vecs();
    @(posedge clk); #3;
    chk("pre-reset phase", int'(phase), 5);
    reset_n = 1'b0;
    #1 chk_state("async reset", 3'b000, '0);

    chk("sb empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
